// File: rtl/tone_pwm_gen.sv
// tone_pwm_gen: turns a 5-bit tone index into a square wave on the buzzer pin.
// Tone changes are only taken at full-period boundaries, so no runt pulses are
// produced except the abrupt mute on en=0 or reset.
// Optional feature: define TONE_GAP_EN to insert a GAP_CYCLES silent
// articulation gap between two different notes.
module tone_pwm_gen #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TONE_W     = 5,
  parameter int CNT_W      = 17,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic [TONE_W-1:0] tone_in,
  output logic              beep,
  output logic              busy,
  output logic [TONE_W-1:0] cur_tone
);

  localparam int NUM_TONES = 1 << TONE_W;
  localparam int NOTE_MAX  = 21;

`ifdef TONE_GAP_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY_HI = 2'd1,
    PLAY_LO = 2'd2,
    GAP     = 2'd3
  } state_t;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY_HI = 2'd1,
    PLAY_LO = 2'd2
  } state_t;
`endif

  // Note frequency in Hz for each index; 0 marks a rest.
  function automatic int note_freq(input int t);
    int f;
    case (t)
      1:       f = 262;
      2:       f = 294;
      3:       f = 330;
      4:       f = 349;
      5:       f = 392;
      6:       f = 440;
      7:       f = 494;
      8:       f = 523;
      9:       f = 587;
      10:      f = 659;
      11:      f = 698;
      12:      f = 784;
      13:      f = 880;
      14:      f = 988;
      15:      f = 1047;
      16:      f = 1175;
      17:      f = 1319;
      18:      f = 1397;
      19:      f = 1568;
      20:      f = 1760;
      21:      f = 1976;
      default: f = 0;
    endcase
    return f;
  endfunction

  // Half period minus one, in clocks; the counters run from this value down to 0.
  function automatic int half_per_m1(input int t);
    int f;
    f = note_freq(t);
    if (f == 0) begin
      return 0;
    end
    return (CLK_FREQ / (2 * f)) - 1;
  endfunction

  // Elaboration-time table of reload values; rests map to 0 and are never loaded.
  logic [CNT_W-1:0] hp_m1_table [NUM_TONES];

  generate
    for (genvar gi = 0; gi < NUM_TONES; gi++) begin : g_hp_table
      localparam int HP_M1 = half_per_m1(gi);
      assign hp_m1_table[gi] = CNT_W'(HP_M1);
    end
  endgenerate

  // A gap length below one clock is meaningless; nothing is built either way.
  generate
    if (GAP_CYCLES < 1) begin : g_gap_len_invalid
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [TONE_W-1:0] cur_tone_reg, cur_tone_next;
  logic [TONE_W-1:0] pend_tone_reg;
  logic              beep_reg, busy_reg;
`ifdef TONE_GAP_EN
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
`endif

  logic              pend_is_note;
  logic [CNT_W-1:0]  pend_hp_m1;
  logic [CNT_W-1:0]  cur_hp_m1;

  assign pend_is_note = (pend_tone_reg != '0) && (pend_tone_reg <= TONE_W'(NOTE_MAX));
  assign pend_hp_m1   = hp_m1_table[pend_tone_reg];
  assign cur_hp_m1    = hp_m1_table[cur_tone_reg];

  // Capture the incoming tone index every cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend_tone_reg <= '0;
    end else begin
      pend_tone_reg <= tone_in;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cur_tone_reg <= '0;
      beep_reg     <= 1'b0;
      busy_reg     <= 1'b0;
`ifdef TONE_GAP_EN
      gap_cnt_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      cur_tone_reg <= cur_tone_next;
      beep_reg     <= (state_next == PLAY_HI);
      busy_reg     <= (state_next != IDLE);
`ifdef TONE_GAP_EN
      gap_cnt_reg  <= gap_cnt_next;
`endif
    end
  end

  // Next-state logic: phase sequencing and period-boundary tone decisions.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cur_tone_next = cur_tone_reg;
`ifdef TONE_GAP_EN
    gap_cnt_next  = gap_cnt_reg;
`endif
    if (!en) begin
      // Abrupt mute: the only case allowed to truncate a pulse.
      state_next    = IDLE;
      cnt_next      = '0;
      cur_tone_next = '0;
`ifdef TONE_GAP_EN
      gap_cnt_next  = '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next      = '0;
          cur_tone_next = '0;
          if (pend_is_note) begin
            state_next    = PLAY_HI;
            cur_tone_next = pend_tone_reg;
            cnt_next      = pend_hp_m1;
          end
        end
        PLAY_HI: begin
          if (cnt_reg == '0) begin
            state_next = PLAY_LO;
            cnt_next   = cur_hp_m1;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        PLAY_LO: begin
          if (cnt_reg == '0) begin
            // Period end: only the index seen right now matters.
            if (pend_tone_reg == cur_tone_reg) begin
              state_next = PLAY_HI;
              cnt_next   = cur_hp_m1;
            end else if (!pend_is_note) begin
              state_next    = IDLE;
              cnt_next      = '0;
              cur_tone_next = '0;
            end else begin
`ifdef TONE_GAP_EN
              // Different note: hold the old index through a silent gap.
              state_next   = GAP;
              cnt_next     = '0;
              gap_cnt_next = GAP_W'(GAP_CYCLES - 1);
`else
              state_next    = PLAY_HI;
              cur_tone_next = pend_tone_reg;
              cnt_next      = pend_hp_m1;
`endif
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
`ifdef TONE_GAP_EN
        GAP: begin
          if (gap_cnt_reg == '0) begin
            if (pend_is_note) begin
              state_next    = PLAY_HI;
              cur_tone_next = pend_tone_reg;
              cnt_next      = pend_hp_m1;
            end else begin
              state_next    = IDLE;
              cur_tone_next = '0;
              cnt_next      = '0;
            end
          end else begin
            gap_cnt_next = gap_cnt_reg - 1'b1;
          end
        end
`endif
        default: begin
          state_next    = IDLE;
          cnt_next      = '0;
          cur_tone_next = '0;
        end
      endcase
    end
  end

  assign beep     = beep_reg;
  assign busy     = busy_reg;
  assign cur_tone = cur_tone_reg;

endmodule

// File: tb/tb_tone_pwm_gen.sv
// Testbench for tone_pwm_gen, run at a scaled-down clock frequency so that
// whole periods fit in a short simulation. A period-level model is checked
// every cycle; directed scenarios check hand-computed lengths.
module tb_tone_pwm_gen;

  localparam int CLK_HZ = 100_000;
  localparam int TW     = 5;
  localparam int GAPC   = 50;
  localparam int FREQ_TAB [22] = '{0, 262, 294, 330, 349, 392, 440, 494,
                                   523, 587, 659, 698, 784, 880, 988,
                                   1047, 1175, 1319, 1397, 1568, 1760, 1976};

  logic          sys_clk = 1'b1;
  logic          sys_rst;
  logic          en;
  logic [TW-1:0] tone_in;
  logic          beep;
  logic          busy;
  logic [TW-1:0] cur_tone;

  int n_checks = 0;
  int n_errors = 0;

  tone_pwm_gen #(
    .CLK_FREQ  (CLK_HZ),
    .TONE_W    (TW),
    .CNT_W     (17),
    .GAP_CYCLES(GAPC)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .tone_in (tone_in),
    .beep    (beep),
    .busy    (busy),
    .cur_tone(cur_tone)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic bit is_note(input int t);
    return (t >= 1) && (t <= 21);
  endfunction

  function automatic int model_hp(input int t, input int clk_hz);
    if (!is_note(t)) return 0;
    return clk_hz / (2 * FREQ_TAB[t]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic measure(input logic lvl, output int len);
    len = 0;
    while (beep === lvl && len < 5000) begin
      len++;
      step(1);
    end
  endtask

  task automatic wait_idle(output int len);
    len = 0;
    while (busy !== 1'b0 && len < 5000) begin
      len++;
      step(1);
    end
  endtask

  // Period-level model: a note is described by its start time within the
  // period; beep is high for the first half_per cycles of each 2*half_per period.
  int   m_pend  = 0;
  int   m_mode  = 0;   // 0 silent, 1 sounding, 2 articulation gap
  int   m_tone  = 0;
  int   m_phase = 0;
  int   m_gap   = 0;
  bit   cmp_on  = 1'b0;

  always @(negedge sys_clk) begin : model_cmp
    logic          exp_beep;
    logic          exp_busy;
    logic [TW-1:0] exp_tone;
    if (cmp_on) begin
      exp_beep = (m_mode == 1) && (m_phase < model_hp(m_tone, CLK_HZ));
      exp_busy = (m_mode != 0);
      exp_tone = (m_mode == 0) ? '0 : TW'(m_tone);
      n_checks++;
      if ({beep, busy, cur_tone} !== {exp_beep, exp_busy, exp_tone}) begin
        n_errors++;
        $display("FAIL cycle_compare t=%0t actual beep=%b busy=%b cur_tone=%0d required beep=%b busy=%b cur_tone=%0d",
                 $time, beep, busy, cur_tone, exp_beep, exp_busy, exp_tone);
      end
    end
    // Advance the model across the coming clock edge.
    if (sys_rst) begin
      m_mode = 0; m_tone = 0; m_phase = 0; m_gap = 0; m_pend = 0;
    end else begin
      if (!en) begin
        m_mode = 0; m_tone = 0; m_phase = 0;
      end else if (m_mode == 0) begin
        if (is_note(m_pend)) begin
          m_mode = 1; m_tone = m_pend; m_phase = 0;
        end
      end else if (m_mode == 1) begin
        if (m_phase == 2 * model_hp(m_tone, CLK_HZ) - 1) begin
          if (m_pend == m_tone) begin
            m_phase = 0;
          end else if (!is_note(m_pend)) begin
            m_mode = 0; m_tone = 0; m_phase = 0;
          end else begin
`ifdef TONE_GAP_EN
            m_mode = 2; m_gap = 0;
`else
            m_tone = m_pend; m_phase = 0;
`endif
          end
        end else begin
          m_phase++;
        end
      end else begin
        if (m_gap == GAPC - 1) begin
          if (is_note(m_pend)) begin
            m_mode = 1; m_tone = m_pend; m_phase = 0;
          end else begin
            m_mode = 0; m_tone = 0;
          end
        end else begin
          m_gap++;
        end
      end
      m_pend = int'(tone_in);
    end
    cmp_on = 1'b1;
  end

  initial begin : stim
    int len;
    int pin_t;
    int seam;
    sys_rst = 1'b1;
    en      = 1'b1;
    tone_in = '0;

    // Pin the model's half-period arithmetic at the real 50 MHz clock.
    pin_t = 6;  check("pin_hp_a4",  model_hp(pin_t, 50_000_000), 56818);
    pin_t = 8;  check("pin_hp_c5",  model_hp(pin_t, 50_000_000), 47801);
    pin_t = 1;  check("pin_hp_c4",  model_hp(pin_t, 50_000_000), 95419);
    pin_t = 21; check("pin_hp_b6",  model_hp(pin_t, 50_000_000), 12651);
    pin_t = 6;  check("pin_hp_a4_scaled", model_hp(pin_t, CLK_HZ), 113);

`ifdef TONE_GAP_EN
    seam = GAPC;
`else
    seam = 0;
`endif

    // Reset and idle.
    step(3);
    sys_rst = 1'b0;
    step(300);
    check("idle_beep", beep, 0);
    check("idle_busy", busy, 0);
    check("idle_tone", cur_tone, 0);
    $display("TXN reset_idle beep=%b busy=%b cur_tone=%0d", beep, busy, cur_tone);

    // A4 steady: rise two cycles after the index appears.
    tone_in = 5'd6;
    step(1);
    check("a4_not_yet", beep, 0);
    step(1);
    check("a4_rise", beep, 1);
    check("a4_tone", cur_tone, 6);
    for (int p = 0; p < 5; p++) begin
      measure(1'b1, len); check("a4_high", len, 113);
      measure(1'b0, len); check("a4_low", len, 113);
    end
    $display("TXN a4_steady periods=5 half=%0d", len);

    // Mid-period change 6 -> 8 at cycle 20 of the high phase.
    step(20);
    tone_in = 5'd8;
    check("chg_old_tone", cur_tone, 6);
    measure(1'b1, len); check("chg_rest_of_high", len, 93);
    measure(1'b0, len); check("chg_low", len, 113 + seam);
    check("chg_new_tone", cur_tone, 8);
    measure(1'b1, len); check("c5_high", len, 95);
    measure(1'b0, len); check("c5_low", len, 95);
    $display("TXN change_6_to_8 cur_tone=%0d", cur_tone);

    // Toggle away and back within one period: no effect.
    step(10);
    tone_in = 5'd3;
    step(5);
    tone_in = 5'd8;
    measure(1'b1, len); check("toggle_high", len, 80);
    measure(1'b0, len); check("toggle_low", len, 95);
    check("toggle_tone", cur_tone, 8);
    measure(1'b1, len); check("toggle_next_high", len, 95);
    $display("TXN toggle_return cur_tone=%0d", cur_tone);

    // Rest: the current low phase completes, then silence.
    tone_in = 5'd0;
    wait_idle(len);
    check("rest_tail", len, 95);
    check("rest_tone", cur_tone, 0);
    $display("TXN rest busy=%b", busy);

    // Lowest note, then highest note across a boundary.
    tone_in = 5'd1;
    step(2);
    check("c4_rise", beep, 1);
    measure(1'b1, len); check("c4_high", len, 190);
    measure(1'b0, len); check("c4_low", len, 190);
    tone_in = 5'd21;
    measure(1'b1, len); check("c4_last_high", len, 190);
    measure(1'b0, len); check("c4_last_low", len, 190 + seam);
    check("b6_tone", cur_tone, 21);
    measure(1'b1, len); check("b6_high", len, 25);
    measure(1'b0, len); check("b6_low", len, 25);
    tone_in = 5'd0;
    wait_idle(len);
    check("b6_idle_busy", busy, 0);
    $display("TXN extremes c4_b6 done");

    // Out-of-range index stays silent.
    tone_in = 5'd25;
    step(50);
    check("oor_beep", beep, 0);
    check("oor_busy", busy, 0);
    check("oor_tone", cur_tone, 0);
    $display("TXN out_of_range busy=%b", busy);

    // Mute mid high phase, then restart.
    tone_in = 5'd10;
    step(2);
    check("e5_rise", beep, 1);
    step(30);
    en = 1'b0;
    step(1);
    check("mute_beep", beep, 0);
    check("mute_busy", busy, 0);
    check("mute_tone", cur_tone, 0);
    step(5);
    en = 1'b1;
    step(1);
    check("unmute_rise", beep, 1);
    measure(1'b1, len); check("unmute_high", len, 75);
    $display("TXN mute_restart high=%0d", len);

    // Reset mid high phase, with en still high.
    measure(1'b0, len); check("pre_rst_low", len, 75);
    step(10);
    sys_rst = 1'b1;
    step(1);
    check("rst_beep", beep, 0);
    check("rst_busy", busy, 0);
    check("rst_tone", cur_tone, 0);
    sys_rst = 1'b0;
    step(1);
    check("rst_no_early_rise", beep, 0);
    step(1);
    check("rst_rise", beep, 1);
    measure(1'b1, len); check("rst_high", len, 75);
    $display("TXN reset_restart high=%0d", len);

    tone_in = 5'd0;
    step(200);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tone_pwm_gen.md
Name: tone_pwm_gen

Overview:
- Downstream of the UART music player. Consumes its 5-bit tone index and drives the passive buzzer pin with a square wave at the note frequency.
- Tone changes take effect only at a full-period boundary, so the output never produces runt pulses.
- Rest and out-of-range indices silence the output.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- TONE_W, 5, width of the tone index.
- CNT_W, 17, half-period counter width. Must hold CLK_FREQ/(2*262).
- GAP_CYCLES, 2_500_000, articulation gap length in clocks (50 ms). Used only with the optional feature.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  synchronous reset, active-high.
- en  input  1  output enable. Low forces silence.
- tone_in  input  TONE_W  tone index from the music player. Level-sampled every cycle.
- beep  output  1  buzzer square wave.
- busy  output  1  high while a note is sounding (PLAY_HI, PLAY_LO or GAP).
- cur_tone  output  TONE_W  index currently being generated. 0 when silent.

Behaviour:
- Tone map:
  - 0 = rest. Indices ≥ 22 = rest.
  - 1..7 = C4..B4: 262, 294, 330, 349, 392, 440, 494 Hz.
  - 8..14 = C5..B5: 523, 587, 659, 698, 784, 880, 988 Hz.
  - 15..21 = C6..B6: 1047, 1175, 1319, 1397, 1568, 1760, 1976 Hz.
- half_per(t) = CLK_FREQ/(2*f), truncated. It is a constant table fixed at elaboration; there is no runtime divider.
- tone_in is registered into pend_tone every cycle.
- States: IDLE, PLAY_HI, PLAY_LO, GAP (GAP exists only with the optional feature).
- IDLE:
  - beep=0, busy=0, cur_tone=0.
  - If en=1 and pend_tone is non-rest: load cur_tone=pend_tone and cnt=half_per-1, then go to PLAY_HI.
  - beep rises 2 cycles after tone_in changes (1 for the input register, 1 for the state register).
- PLAY_HI:
  - beep=1, cnt decrements each cycle.
  - At cnt==0: reload cnt=half_per-1 and go to PLAY_LO.
  - The high phase lasts exactly half_per cycles.
- PLAY_LO:
  - beep=0, cnt decrements each cycle.
  - At cnt==0 (period end), decide the next state:
    - pend_tone==cur_tone: reload and go to PLAY_HI.
    - pend_tone is rest: go to IDLE.
    - pend_tone is a different note: load the new cur_tone and half_per, go to PLAY_HI.
- Mid-period tone change: ignored until the current period ends. A tone that toggles and returns to its original value within one period produces no change.
- en=0 in any state: next cycle goes to IDLE with beep=0 and cnt=0. This abrupt mute is the only permitted truncated pulse.
- sys_rst=1: next edge gives state=IDLE, beep=0, busy=0, cur_tone=0, cnt=0, pend_tone=0. Reset mid-note behaves the same. Reset dominates en.
- busy equals (state!=IDLE). All outputs are registered.
- Simultaneous events: at a period end, the value of pend_tone in that cycle decides the next state. Earlier values are not remembered.

Optional Feature:
- Macro: TONE_GAP_EN.
- Defined:
  - At a PLAY_LO period end with a different non-rest pend_tone, enter GAP instead of PLAY_HI.
  - GAP: beep=0, busy=1, cur_tone holds the old note; counts GAP_CYCLES.
  - At the end of GAP, load the pend_tone sampled at that moment and go to PLAY_HI. If that value is rest, go to IDLE.
  - A repeated identical index does not trigger a gap.
  - en=0 or reset in GAP goes to IDLE.
- Undefined: the GAP state and its counter are absent; different-note transitions are seamless.

Test Plan:
- Reset/idle: assert sys_rst 3 cycles, en=1, tone_in=0 → beep=0, busy=0, cur_tone=0 for 10,000 cycles.
- A4 steady: tone_in=6 from IDLE → beep rises 2 cycles later; high exactly 56818 cycles, low 56818 cycles; 5 periods checked.
- Change mid-period: tone 6 playing, tone_in=8 at cycle 20,000 of the high phase → tone 6 period completes (113,636 cycles total); next high phase is 47801 cycles; cur_tone switches to 8 at the boundary.
- Extremes: tone_in=1 → half period 95419 (no counter overflow); tone_in=21 → 12651; tone_in=25 → silent, busy=0.
- Mute/reset mid-note: en=0 during PLAY_HI of tone 10 → beep=0 next cycle, IDLE. Repeat with sys_rst=1 → all outputs zero next edge. en=1 again → clean restart with a full high phase.
- TONE_GAP_EN: tone 6 → 8 at period end → exactly 2,500,000 silent cycles with busy=1, then 47801-cycle high. 6 → 6 produces no gap.
